// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam int ALU_LAT_DEF = 2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } res_t;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command (upstream) and result (downstream) valid/ready channels of the sequencer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_op;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    output cmd_ready, res_valid, res_data, res_op
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_data, res_op
  );
endinterface

// File: rtl/alu_cmd_sequencer_sync_fifo.sv
// Synchronous FIFO with a registered head: dout is loaded at the edge with the entry
// that will be at the head next cycle, and holds its last value while empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr, rd_nxt;
  logic                        do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      // Head look-ahead: next stored entry, or the incoming word when it becomes the head.
      if (do_pop && count > (AW+1)'(1))  dout <= mem[rd_nxt];
      else if (do_push && (empty || do_pop)) dout <= din;
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them under a result-FIFO credit check, tracks the fixed
// ALU latency with a valid/op pipe and captures every result into a result FIFO.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = ALU_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [1:0]           alu_op,
  input  logic [7:0]           alu_out,
  output logic                 idle
);
  localparam int SW = $clog2(RES_DEPTH + ALU_LAT + 1);

  cmd_t cmd_in, cmd_head;
  res_t res_in, res_head;
  logic cmd_full, cmd_empty, res_full, res_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic [$clog2(RES_DEPTH):0] res_count;
  logic issue, res_pop;
  logic [ALU_LAT-1:0]       vld_pipe;
  logic [ALU_LAT-1:0][1:0]  op_pipe;
  logic [SW-1:0]            inflight;

  assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
  assign res_in = '{op: op_pipe[ALU_LAT-1], data: alu_out};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) inflight = inflight + SW'(vld_pipe[i]);
  end

  // Every issued op owns a result slot until popped, so the result FIFO cannot overflow.
  assign issue   = !cmd_empty && !res_full && (SW'(res_count) + inflight < SW'(RES_DEPTH));
  assign res_pop = bus.res_ready && !res_empty;

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(clk), .rst(rst),
    .push(bus.cmd_valid), .pop(issue), .din(cmd_in), .dout(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );

  sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res (
    .clk(clk), .rst(rst),
    .push(vld_pipe[ALU_LAT-1]), .pop(res_pop), .din(res_in), .dout(res_head),
    .full(res_full), .empty(res_empty), .count(res_count)
  );

  // The command head register is the ALU drive: it already holds the op issued this cycle.
  assign alu_a  = cmd_head.a;
  assign alu_b  = cmd_head.b;
  assign alu_op = cmd_head.op;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      op_pipe  <= '0;
    end else begin
      vld_pipe[0] <= issue;
      op_pipe[0]  <= cmd_head.op;
      for (int i = 1; i < ALU_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        op_pipe[i]  <= op_pipe[i-1];
      end
    end
  end

  assign bus.cmd_ready = !cmd_full;
  assign bus.res_valid = !res_empty;
  assign bus.res_data  = res_head.data;
  assign bus.res_op    = res_head.op;
  assign idle = (cmd_count == '0) && (res_count == '0) && (vld_pipe == '0);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised scenario bench for alu_cmd_sequencer with a 2-cycle ALU model and an
// in-order expected-result queue built from accepted commands.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 4;
  localparam int ALU_LAT   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_out, alu_s1;
  logic       idle;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .idle(idle)
  );

  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    case (op)
      OP_ADD:  return 8'(a) + 8'(b);
      OP_MUL:  return 8'(a) * 8'(b);
      OP_OR:   return {4'd0, a | b};
      default: return {4'd0, a & b};
    endcase
  endfunction

  // Free-running, unresettable 2-stage ALU.
  always @(posedge clk) begin
    alu_s1  <= ref_alu(alu_a, alu_b, alu_op);
    alu_out <= alu_s1;
  end

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted command yields one result, in order; reset drops all.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back({bus.cmd_op, ref_alu(bus.cmd_a, bus.cmd_b, bus.cmd_op)});
      if (bus.res_valid && bus.res_ready) begin
        got_q.push_back({bus.res_op, bus.res_data});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  // Holds cmd_valid until accepted; returns one phase after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      output int acc);
    bit done = 1'b0;
    acc = -1;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin done = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
  endtask

  task automatic settle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (idle && got_q.size() == exp_q.size()) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_op = 0; bus.res_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); else pass_cnt++;
    total++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid got %b exp 0", bus.res_valid); else pass_cnt++;
    total++; if (bus.res_data !== 8'd0) $display("FAIL rst_res_data got %0d exp 0", bus.res_data); else pass_cnt++;
    total++; if (bus.res_op !== 2'd0) $display("FAIL rst_res_op got %0d exp 0", bus.res_op); else pass_cnt++;
    total++; if ({alu_a, alu_b, alu_op} !== 10'd0) $display("FAIL rst_alu_drive got %h exp 0", {alu_a, alu_b, alu_op}); else pass_cnt++;
    total++; if (idle !== 1'b1) $display("FAIL rst_idle got %b exp 1", idle); else pass_cnt++;
    @(posedge clk); #1;
    clear_queues();
  endtask

  task automatic test_single_op();
    int acc;
    bus.res_ready = 1'b1;
    send(4'd3, 4'd5, OP_ADD, acc);
    bus.cmd_valid = 1'b0;
    settle(50);
    total++; if (got_q.size() !== 1) $display("FAIL single_count got %0d exp 1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== {OP_ADD, 8'd8}) $display("FAIL single_result got %h exp %h", got_q[0], {OP_ADD, 8'd8}); else pass_cnt++;
      total++; if (got_cyc[0] - acc !== ALU_LAT + 2) $display("FAIL single_latency got %0d exp %0d", got_cyc[0] - acc, ALU_LAT + 2); else pass_cnt++;
    end
    @(negedge clk);
    total++; if (idle !== 1'b1) $display("FAIL single_idle got %b exp 1", idle); else pass_cnt++;
    @(posedge clk); #1;
    clear_queues();
  endtask

  task automatic test_all_ops();
    logic [3:0] ta[4] = '{4'd15, 4'd12, 4'd12, 4'd15};
    logic [3:0] tb[4] = '{4'd15, 4'd10, 4'd10, 4'd15};
    logic [1:0] to[4] = '{OP_MUL, OP_OR, OP_AND, OP_ADD};
    logic [7:0] te[4] = '{8'd225, 8'd14, 8'd8, 8'd30};
    int acc;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(ta[i], tb[i], to[i], acc);
    bus.cmd_valid = 1'b0;
    settle(50);
    total++; if (got_q.size() !== 4) $display("FAIL ops_count got %0d exp 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++; if (got_q[i] !== {to[i], te[i]}) $display("FAIL ops_result[%0d] got %h exp %h", i, got_q[i], {to[i], te[i]}); else pass_cnt++;
      if (i > 0) begin
        total++; if (got_cyc[i] - got_cyc[i-1] !== 1) $display("FAIL ops_spacing[%0d] got %0d exp 1", i, got_cyc[i] - got_cyc[i-1]); else pass_cnt++;
      end
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    int acc;
    bus.res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(4'($urandom), 4'($urandom), 2'($urandom), acc);
        bus.cmd_valid = 1'b0;
      end
      begin
        repeat (25) @(negedge clk);
        total++; if (exp_q.size() !== RES_DEPTH + CMD_DEPTH) $display("FAIL bp_accepted got %0d exp %0d", exp_q.size(), RES_DEPTH + CMD_DEPTH); else pass_cnt++;
        total++; if (bus.cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready got %b exp 0", bus.cmd_ready); else pass_cnt++;
        total++; if (bus.res_valid !== 1'b1) $display("FAIL bp_res_valid got %b exp 1", bus.res_valid); else pass_cnt++;
        total++; if (got_q.size() !== 0) $display("FAIL bp_early_pop got %0d exp 0", got_q.size()); else pass_cnt++;
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
      end
    join
    settle(200);
    total++; if (exp_q.size() !== 10) $display("FAIL bp_total_accepted got %0d exp 10", exp_q.size()); else pass_cnt++;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_delivered got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int acc;
    int bad = 0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < RES_DEPTH + CMD_DEPTH; i++) send(4'($urandom), 4'($urandom), 2'($urandom), acc);
    bus.cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.res_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 26; i++) send(4'($urandom), 4'($urandom), 2'($urandom), acc);
        bus.cmd_valid = 1'b0;
      end
      begin
        // Two cycles to refill the pipe, then push and pop must hit both FIFOs every cycle.
        repeat (3) @(negedge clk);
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (!(bus.cmd_valid && bus.cmd_ready && bus.res_valid && bus.res_ready)) bad++;
        end
        total++; if (bad !== 0) $display("FAIL b2b_stall_cycles got %0d exp 0", bad); else pass_cnt++;
      end
    join
    settle(200);
    total++; if (exp_q.size() !== 34) $display("FAIL b2b_accepted got %0d exp 34", exp_q.size()); else pass_cnt++;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_delivered got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    clear_queues();
  endtask

  task automatic test_reset_midflight();
    int acc;
    int seen = 0;
    bus.res_ready = 1'b1;
    send(4'd9, 4'd7, OP_MUL, acc);
    send(4'd6, 4'd11, OP_ADD, acc);
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0) $display("FAIL mid_res_valid got %b exp 0", bus.res_valid); else pass_cnt++;
    total++; if (idle !== 1'b1) $display("FAIL mid_idle got %b exp 1", idle); else pass_cnt++;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    total++; if (seen !== 0 || got_q.size() !== 0) $display("FAIL mid_stale got %0d/%0d exp 0/0", seen, got_q.size()); else pass_cnt++;
    @(posedge clk); #1;
    clear_queues();
    send(4'd13, 4'd2, OP_OR, acc);
    bus.cmd_valid = 1'b0;
    settle(50);
    total++; if (got_q.size() !== 1) $display("FAIL mid_after_count got %0d exp 1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== {OP_OR, 8'd15}) $display("FAIL mid_after_result got %h exp %h", got_q[0], {OP_OR, 8'd15}); else pass_cnt++;
    end
    clear_queues();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_a     = 4'($urandom);
      bus.cmd_b     = 4'($urandom);
      bus.cmd_op    = 2'($urandom);
      bus.res_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    settle(200);
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
